execute_muldiv_unit: RTL and testbench
======================================

Name: execute_muldiv_unit

Overview:
- Execute-stage HI/LO multiply/divide unit.
- Consumes operands and control from the decode/execute pipeline register: src_a_E, src_b_E, and an op code derived from opcode_E/funct_E.
- Runs MULT/MULTU/DIV/DIVU iteratively and owns the architectural HI/LO registers.
- Raises busy to the hazard unit, which stalls the pipeline while an operation is in flight.

Parameters:
WIDTH_32, 32, operand and HI/LO width
CNT_W, 5, iteration counter width (log2 WIDTH_32)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous active-high reset
start  in  1  execute-stage op valid; sampled only when idle
op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
flush  in  1  cancel in-flight operation (execute-stage flush)
src_a  in  32  rs operand (dividend / multiplicand / MTHI/MTLO data)
src_b  in  32  rt operand (divisor / multiplier)
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  registered; high while state != IDLE
done  out  1  registered one-cycle pulse when HI/LO take a mul/div result
div_by_zero  out  1  registered pulse coincident with done for a DIV/DIVU with src_b==0

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0. Reset wins over every other input, including mid-operation.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op 0-3 (edge 1):
  - Latch |a|, |b| for signed ops; raw values for unsigned ops.
  - Latch result-sign flags and the op.
  - counter=0; go to CALC.
- IDLE, start=1, op 4/5: write hi (MTHI) or lo (MTLO) at that edge. No state change, no done.
- IDLE, start=1, op 6-7: ignored.
- CALC: one radix-2 iteration per edge.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract.
  - counter increments each edge; the edge with counter==31 goes to FIX. This is 32 CALC edges, edges 2-33.
- FIX (edge 34):
  - Apply sign correction.
  - Multiply: {hi,lo} = 64-bit product; negated if signed and sign(a)^sign(b).
  - Divide: lo = quotient, negated if sign(a)^sign(b); hi = remainder, sign of the dividend.
  - Go to IDLE, with done=1 for the following cycle.
- Divide by zero (src_b==0, DIV or DIVU): lo=32'hFFFF_FFFF, hi=dividend as supplied (src_a), div_by_zero=1 with done. Timing is unchanged (34 edges).
- DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0. No flag.
- busy:
  - Goes high after edge 1 and low after edge 34.
  - Hazard unit stalls MFHI/MFLO and any further mul/div/MTHI/MTLO while busy.
  - start while busy is ignored; it is the upstream's job not to issue.
- flush:
  - In CALC or FIX: return to IDLE next edge; hi/lo unchanged; no done.
  - In IDLE: a simultaneous start is suppressed.
  - flush has priority over start.
- hi/lo change only on reset, MTHI/MTLO in IDLE, or the FIX edge.

Optional Feature:
Macro FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 32x32 multiplier. On edge 1, {hi,lo} is written directly and done pulses the next cycle; busy never rises for multiplies. DIV/DIVU are unchanged.
- Undefined: multiplies take the iterative 34-edge path described above. No multiplier macro is inferred.

Test Plan:
- Reset, then MULTU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> after edge 34: hi=32'hFFFF_FFFE, lo=32'h0000_0001; done one cycle; busy high for exactly 33 cycles (iterative build).
- MULT -7 x 3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. With FAST_MULT_EN, the same values appear after edge 1 and busy stays 0.
- DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU 100 / 7 -> lo=14, hi=2.
- DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0. DIVU 5 / 0 -> lo=32'hFFFF_FFFF, hi=5, div_by_zero=1 with done.
- MTHI 32'h1234_5678 then MTLO 32'h9ABC_DEF0 in IDLE -> hi/lo updated on the start edge. A second DIV issued while busy is ignored: results match the first op only.
- DIV started with prior hi=lo=32'hAAAA_AAAA; flush at edge 10 -> IDLE next cycle, hi/lo still 32'hAAAA_AAAA, no done. Repeat with rst at edge 10 -> hi=lo=0, busy=0.

Source files
------------

// File: rtl/execute_muldiv_unit_if.sv
// Execute-stage mul/div handshake and HI/LO bundle between pipeline control and the unit.
interface execute_muldiv_unit_if #(
  parameter int WIDTH_32 = 32
);
  logic                start;
  logic [2:0]          op;
  logic                flush;
  logic [WIDTH_32-1:0] src_a;
  logic [WIDTH_32-1:0] src_b;
  logic [WIDTH_32-1:0] hi;
  logic [WIDTH_32-1:0] lo;
  logic                busy;
  logic                done;
  logic                div_by_zero;

  modport master (
    output start, op, flush, src_a, src_b,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op, flush, src_a, src_b,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 34 edges per op.
// Define FAST_MULT_EN for a single-cycle multiplier (divides stay iterative).
module execute_muldiv_unit #(
  parameter int WIDTH_32 = 32,
  parameter int CNT_W    = 5
) (
  input logic                 clk,
  input logic                 rst,
  execute_muldiv_unit_if.slave bus
);
  localparam int W = WIDTH_32;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     a_abs, b_abs, a_abs_in, b_abs_in;
  logic [2*W-1:0]   acc, acc_step;
  logic             is_div, sgn_a, sgn_b, dz;
  logic [W-1:0]     hi_q, lo_q;
  logic             busy_q, done_q, dz_q;
  logic             accept, op_md, op_mt, iter_start, signed_op;
  logic [W:0]       mul_sum, div_diff;
  logic [2*W-1:0]   prod_fix;
  logic [W-1:0]     div_lo_fix, div_hi_fix;

  assign accept    = (state == IDLE) && bus.start && !bus.flush;
  assign op_md     = accept && !bus.op[2];
  assign op_mt     = accept && (bus.op == 3'd4 || bus.op == 3'd5);
  assign signed_op = !bus.op[0];
  assign a_abs_in  = (signed_op && bus.src_a[W-1]) ? -bus.src_a : bus.src_a;
  assign b_abs_in  = (signed_op && bus.src_b[W-1]) ? -bus.src_b : bus.src_b;

`ifdef FAST_MULT_EN
  logic           fast_mul;
  logic [2*W-1:0] fast_prod;
  assign fast_mul   = op_md && !bus.op[1];
  assign iter_start = op_md && bus.op[1];
  always_comb begin
    fast_prod = '0;
    if (bus.op[0]) fast_prod = bus.src_a * bus.src_b;
    else           fast_prod = $signed(bus.src_a) * $signed(bus.src_b);
  end
`else
  assign iter_start = op_md;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iter_start) state_nxt = CALC;
      CALC:    if (bus.flush) state_nxt = IDLE;
               else if (cnt == '1) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Multiply keeps the multiplier in acc's low half and shifts right;
  // divide keeps {remainder, quotient} and shifts left.
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, a_abs};
    div_diff = acc[2*W-1:W-1] - {1'b0, b_abs};
    if (is_div)
      acc_step = div_diff[W] ? {acc[2*W-2:0], 1'b0}
                             : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_step = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
  end

  always_comb begin
    prod_fix   = (sgn_a ^ sgn_b) ? -acc : acc;
    div_lo_fix = (sgn_a ^ sgn_b) ? -acc[W-1:0] : acc[W-1:0];
    div_hi_fix = sgn_a ? -acc[2*W-1:W] : acc[2*W-1:W];
    if (dz) begin
      div_lo_fix = '1;
      div_hi_fix = sgn_a ? -a_abs : a_abs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_abs  <= '0;
      b_abs  <= '0;
      acc    <= '0;
      is_div <= 1'b0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      dz     <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      busy_q <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (op_mt) begin
            if (bus.op == 3'd4) hi_q <= bus.src_a;
            else                lo_q <= bus.src_a;
          end
`ifdef FAST_MULT_EN
          if (fast_mul) begin
            {hi_q, lo_q} <= fast_prod;
            done_q       <= 1'b1;
          end
`endif
          if (iter_start) begin
            a_abs  <= a_abs_in;
            b_abs  <= b_abs_in;
            sgn_a  <= signed_op && bus.src_a[W-1];
            sgn_b  <= signed_op && bus.src_b[W-1];
            is_div <= bus.op[1];
            dz     <= bus.op[1] && (bus.src_b == '0);
            acc    <= bus.op[1] ? {{W{1'b0}}, a_abs_in} : {{W{1'b0}}, b_abs_in};
            cnt    <= '0;
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            if (is_div) begin
              hi_q <= div_hi_fix;
              lo_q <= div_lo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
            done_q <= 1'b1;
            dz_q   <= dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: vector table with scoreboard plus flush/reset sequences.
module tb_execute_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_muldiv_unit_if #(.WIDTH_32(32)) bus ();

  execute_muldiv_unit #(.WIDTH_32(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FAST_MULT_EN
  localparam int MUL_BUSY = 0;
`else
  localparam int MUL_BUSY = 33;
`endif
  localparam int DIV_BUSY = 33;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          busy;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.src_a = a;
    bus.src_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd7;
  endtask

  // Waits for done (bounded), then checks the oldest scoreboard entry.
  task automatic wait_and_check(input string name, input bit check_busy);
    int   busy_cnt;
    bit   seen;
    exp_t e;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
    if (!seen) begin
      fails++;
      checks++;
      $display("FAIL %s timeout: got no done expected done within 200 cycles", name);
      return;
    end
    if (sb.size() == 0) begin
      fails++;
      checks++;
      $display("FAIL %s: got done expected no pending result", name);
      return;
    end
    e = sb.pop_front();
    chk({name, " hi"}, bus.hi, e.hi);
    chk({name, " lo"}, bus.lo, e.lo);
    chk({name, " dz"}, {31'd0, bus.div_by_zero}, {31'd0, e.dz});
    chk({name, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    if (check_busy) chk({name, " busy_cycles"}, busy_cnt, e.busy);
    @(negedge clk);
    chk({name, " done_pulse"}, {31'd0, bus.done}, 32'd0);
    chk({name, " dz_pulse"}, {31'd0, bus.div_by_zero}, 32'd0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done) n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    exp_t e;
    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{3'd0, 32'hFFFF_FFF9, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{3'd0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.flush = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset dz", {31'd0, bus.div_by_zero}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      e.hi   = vecs[i].hi;
      e.lo   = vecs[i].lo;
      e.dz   = vecs[i].dz;
      e.busy = vecs[i].op[1] ? DIV_BUSY : MUL_BUSY;
      sb.push_back(e);
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_and_check($sformatf("vec%0d", i), 1'b1);
    end

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi hi", bus.hi, 32'h1234_5678);
    chk("mthi busy", {31'd0, bus.busy}, 32'd0);
    chk("mthi done", {31'd0, bus.done}, 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo lo", bus.lo, 32'h9ABC_DEF0);
    chk("mtlo hi kept", bus.hi, 32'h1234_5678);
    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("noop hi", bus.hi, 32'h1234_5678);
    chk("noop busy", {31'd0, bus.busy}, 32'd0);

    // flush beats a simultaneous start in IDLE
    bus.flush = 1'b1;
    issue(3'd4, 32'h5555_5555, 32'd0);
    bus.flush = 1'b0;
    chk("flush_idle hi", bus.hi, 32'h1234_5678);

    e = '{32'd2, 32'd14, 1'b0, DIV_BUSY};
    sb.push_back(e);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    issue(3'd2, 32'd50, 32'd3);
    wait_and_check("div_while_busy", 1'b0);
    count_done(45, n);
    chk("div_while_busy extra done", n, 0);
    chk("div_while_busy idle", {31'd0, bus.busy}, 32'd0);
    chk("div_while_busy lo kept", bus.lo, 32'd14);

    issue(3'd4, 32'hAAAA_AAAA, 32'd0);
    issue(3'd5, 32'hAAAA_AAAA, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", {31'd0, bus.busy}, 32'd0);
    chk("flush hi", bus.hi, 32'hAAAA_AAAA);
    chk("flush lo", bus.lo, 32'hAAAA_AAAA);
    count_done(45, n);
    chk("flush no done", n, 0);
    chk("flush hi later", bus.hi, 32'hAAAA_AAAA);

    issue(3'd2, 32'd100, 32'd7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_mid hi", bus.hi, 32'd0);
    chk("rst_mid lo", bus.lo, 32'd0);
    count_done(45, n);
    chk("rst_mid no done", n, 0);

    e = '{32'h0000_0000, 32'h8000_0000, 1'b0, DIV_BUSY};
    sb.push_back(e);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_and_check("post_rst div", 1'b1);
    chk("scoreboard empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
